// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory address/data pair, the
// decode-side control inputs (stall, redirect) and the IF/ID output bundle.
// The master modport is the fetch unit; slave is the surrounding pipeline/memory.
interface fetch_pc_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            id_stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_valid;
    logic            fetch_fault;

    modport master (
        output imem_addr,
        output if_instr,
        output if_pc,
        output if_valid,
        output fetch_fault,
        input  imem_data,
        input  id_stall,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        input  if_instr,
        input  if_pc,
        input  if_valid,
        input  fetch_fault,
        output imem_data,
        output id_stall,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer in front of a synchronous-read,
// word-addressed instruction memory. Tracks which PC the registered memory
// output belongs to and presents {instr, pc, valid} to IF/ID.
// Optional performance counters are compiled in with `define FETCH_PERF_EN.
module fetch_pc_unit #(
    parameter int unsigned    PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned    IMEM_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_pc_unit_if.master    bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);

    logic [PC_W-1:0] pc_q, pc_d;          // next sequential fetch address
    logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;  // address whose data is on imem_data
    logic            rsp_valid_q, rsp_valid_d;
    logic            fault_q, fault_d;

    logic [PC_W-1:0] issue_addr;
    logic            hold_rsp;
    logic            new_fault;
    logic            if_valid_w;

    // Select the address issued to memory this cycle and flag out-of-range issues.
    always_comb begin
        hold_rsp   = bus.id_stall && rsp_valid_q;
        issue_addr = pc_q;
        if (fault_q) begin
            issue_addr = pc_q;
        end else if (bus.redirect) begin
            issue_addr = bus.redirect_pc;
        end else if (hold_rsp) begin
            // Re-read the held instruction so imem_data stays stable.
            issue_addr = rsp_pc_q;
        end
        new_fault = !fault_q && (issue_addr >= DEPTH);
    end

    // Next-state: fault freezes everything, redirect beats stall, stall beats advance.
    always_comb begin
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        fault_d     = fault_q;
        if (!fault_q) begin
            if (new_fault) begin
                fault_d     = 1'b1;
                rsp_valid_d = 1'b0;
            end else if (bus.redirect) begin
                rsp_pc_d    = issue_addr;
                rsp_valid_d = 1'b1;
                pc_d        = issue_addr + 1'b1;
            end else if (bus.id_stall) begin
                // With nothing held yet, the stalled cycle still issues pc_q
                // but does not step past it.
                if (!rsp_valid_q) begin
                    rsp_pc_d    = issue_addr;
                    rsp_valid_d = 1'b1;
                end
            end else begin
                rsp_pc_d    = issue_addr;
                rsp_valid_d = 1'b1;
                pc_d        = issue_addr + 1'b1;
            end
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
        end
    end

    // A redirect kills the wrong-path instruction currently on the memory output.
    assign if_valid_w      = rsp_valid_q && !bus.redirect && !fault_q;
    assign bus.imem_addr   = issue_addr;
    assign bus.if_instr    = bus.imem_data;
    assign bus.if_pc       = rsp_pc_q;
    assign bus.if_valid    = if_valid_w;
    assign bus.fetch_fault = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Count accepted instructions and cycles where a live instruction was stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else if (if_valid_w) begin
            if (bus.id_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: free-run, stall, redirect, redirect during
// stall, fault via redirect and via running off the end, plus perf counters
// when FETCH_PERF_EN is defined. Memory model: MEM[k] = k*0x11, 1-cycle read.
module tb_fetch_pc_unit;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    fetch_pc_unit_if #(.PC_W(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_pc_unit #(
        .PC_W       (32),
        .RESET_PC   (32'd0),
        .IMEM_DEPTH (128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory model.
    logic [31:0] mem [0:127];
    initial begin
        for (int k = 0; k < 128; k++) mem[k] = k * 32'h11;
    end
    always @(posedge clk) begin
        if (bus.imem_addr < 32'd128) bus.imem_data <= mem[bus.imem_addr[6:0]];
        else                         bus.imem_data <= 32'hDEAD_BEEF;
    end

    task automatic show(input string tag);
        $display("[%0t] %s addr=%0d pc=%0d instr=%08h valid=%b fault=%b stall=%b redir=%b",
                 $time, tag, bus.imem_addr, bus.if_pc, bus.if_instr, bus.if_valid,
                 bus.fetch_fault, bus.id_stall, bus.redirect);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.id_stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        show("reset");
        vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", bus.if_valid); end
        vecs++; if (bus.if_pc !== 32'd0) begin errs++; $display("FAIL reset_pc: got %0d expected 0", bus.if_pc); end
        vecs++; if (bus.fetch_fault !== 1'b0) begin errs++; $display("FAIL reset_fault: got %b expected 0", bus.fetch_fault); end
        vecs++; if (bus.imem_addr !== 32'd0) begin errs++; $display("FAIL reset_addr: got %0d expected 0", bus.imem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            show("run");
            exp_instr = k * 32'h11;
            vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL run_valid: got %b expected 1", bus.if_valid); end
            vecs++; if (bus.if_pc !== 32'(k)) begin errs++; $display("FAIL run_pc: got %0d expected %0d", bus.if_pc, k); end
            vecs++; if (bus.if_instr !== exp_instr) begin errs++; $display("FAIL run_instr: got %h expected %h", bus.if_instr, exp_instr); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.id_stall = 1'b1;
            #1;
            show("stall");
            vecs++; if (bus.if_pc !== 32'd4) begin errs++; $display("FAIL stall_pc: got %0d expected 4", bus.if_pc); end
            vecs++; if (bus.if_instr !== 32'h44) begin errs++; $display("FAIL stall_instr: got %h expected 44", bus.if_instr); end
            vecs++; if (bus.imem_addr !== 32'd4) begin errs++; $display("FAIL stall_addr: got %0d expected 4", bus.imem_addr); end
            vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL stall_valid: got %b expected 1", bus.if_valid); end
        end
        @(negedge clk);
        bus.id_stall = 1'b0;
        #1;
        show("release");
        vecs++; if (bus.if_pc !== 32'd4) begin errs++; $display("FAIL release_pc: got %0d expected 4", bus.if_pc); end
        @(negedge clk);
        #1;
        show("run");
        vecs++; if (bus.if_pc !== 32'd5) begin errs++; $display("FAIL after_stall_pc: got %0d expected 5", bus.if_pc); end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd20;
        #1;
        show("redirect");
        vecs++; if (bus.if_pc !== 32'd6) begin errs++; $display("FAIL redir_old_pc: got %0d expected 6", bus.if_pc); end
        vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL redir_kill: got %b expected 0", bus.if_valid); end
        vecs++; if (bus.imem_addr !== 32'd20) begin errs++; $display("FAIL redir_addr: got %0d expected 20", bus.imem_addr); end
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        show("target");
        vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL target_valid: got %b expected 1", bus.if_valid); end
        vecs++; if (bus.if_pc !== 32'd20) begin errs++; $display("FAIL target_pc: got %0d expected 20", bus.if_pc); end
        vecs++; if (bus.if_instr !== 32'h154) begin errs++; $display("FAIL target_instr: got %h expected 154", bus.if_instr); end
        @(negedge clk);
        #1;
        show("run");
        vecs++; if (bus.if_pc !== 32'd21) begin errs++; $display("FAIL target_next_pc: got %0d expected 21", bus.if_pc); end
        vecs++; if (bus.if_instr !== 32'h165) begin errs++; $display("FAIL target_next_instr: got %h expected 165", bus.if_instr); end
    endtask

    task automatic test_redirect_stall();
        @(negedge clk);
        bus.id_stall = 1'b1;
        #1;
        show("stall");
        vecs++; if (bus.if_pc !== 32'd22) begin errs++; $display("FAIL rs_hold_pc: got %0d expected 22", bus.if_pc); end
        @(negedge clk);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd40;
        #1;
        show("stall+redirect");
        vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL rs_kill: got %b expected 0", bus.if_valid); end
        vecs++; if (bus.imem_addr !== 32'd40) begin errs++; $display("FAIL rs_addr: got %0d expected 40", bus.imem_addr); end
        @(negedge clk);
        bus.id_stall = 1'b0;
        bus.redirect = 1'b0;
        #1;
        show("target");
        vecs++; if (bus.if_pc !== 32'd40) begin errs++; $display("FAIL rs_target_pc: got %0d expected 40", bus.if_pc); end
        vecs++; if (bus.if_instr !== 32'h2A8) begin errs++; $display("FAIL rs_target_instr: got %h expected 2a8", bus.if_instr); end
        vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL rs_target_valid: got %b expected 1", bus.if_valid); end
    endtask

    task automatic test_fault_redirect();
        // Memory side has issued 41 by now; pc_q sits at 42.
        @(negedge clk);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd200;
        #1;
        show("redirect200");
        vecs++; if (bus.fetch_fault !== 1'b0) begin errs++; $display("FAIL pre_fault: got %b expected 0", bus.fetch_fault); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.redirect = (i >= 1);
            bus.redirect_pc = 32'd5;
            #1;
            show("faulted");
            vecs++; if (bus.fetch_fault !== 1'b1) begin errs++; $display("FAIL fault_set: got %b expected 1", bus.fetch_fault); end
            vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL fault_valid: got %b expected 0", bus.if_valid); end
            vecs++; if (bus.imem_addr !== 32'd42) begin errs++; $display("FAIL fault_addr: got %0d expected 42", bus.imem_addr); end
        end
        bus.redirect = 1'b0;
    endtask

    task automatic test_seq_fault();
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            #1;
            show("run");
            vecs++; if (bus.if_pc !== 32'(k)) begin errs++; $display("FAIL seq_pc: got %0d expected %0d", bus.if_pc, k); end
        end
        vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL last_valid: got %b expected 1", bus.if_valid); end
        vecs++; if (bus.if_instr !== 32'h86F) begin errs++; $display("FAIL last_instr: got %h expected 86f", bus.if_instr); end
        vecs++; if (bus.imem_addr !== 32'd128) begin errs++; $display("FAIL last_addr: got %0d expected 128", bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            show("faulted");
            vecs++; if (bus.fetch_fault !== 1'b1) begin errs++; $display("FAIL seq_fault: got %b expected 1", bus.fetch_fault); end
            vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL seq_fault_valid: got %b expected 0", bus.if_valid); end
        end
    endtask

    task automatic test_restart();
        @(negedge clk);
        #1;
        show("restart");
        vecs++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL restart_valid: got %b expected 1", bus.if_valid); end
        vecs++; if (bus.if_pc !== 32'd0) begin errs++; $display("FAIL restart_pc: got %0d expected 0", bus.if_pc); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        vecs++; if (perf_fetch_cnt !== 32'd0) begin errs++; $display("FAIL perf_fetch_reset: got %0d expected 0", perf_fetch_cnt); end
        vecs++; if (perf_stall_cnt !== 32'd0) begin errs++; $display("FAIL perf_stall_reset: got %0d expected 0", perf_stall_cnt); end
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.id_stall = (i >= 5 && i < 8);
            #1;
            show("perf");
        end
        @(negedge clk);
        bus.id_stall = 1'b0;
        #1;
        vecs++; if (perf_fetch_cnt !== 32'd10) begin errs++; $display("FAIL perf_fetch: got %0d expected 10", perf_fetch_cnt); end
        vecs++; if (perf_stall_cnt !== 32'd3) begin errs++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vecs++; if (perf_fetch_cnt !== 32'd0) begin errs++; $display("FAIL perf_fetch_clr: got %0d expected 0", perf_fetch_cnt); end
        vecs++; if (perf_stall_cnt !== 32'd0) begin errs++; $display("FAIL perf_stall_clr: got %0d expected 0", perf_stall_cnt); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_fault_redirect();
        test_reset();
        test_restart();
        test_reset();
        test_seq_fault();
        test_reset();
        test_restart();
`ifdef FETCH_PERF_EN
        test_reset();
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
